md_seq: RTL



---
 rtl/md_seq.sv | 102 ++++++++++
 1 files changed

// File: rtl/md_seq.sv
// Multi-cycle multiply/divide unit with architectural HI/LO for the E stage.
// Results are computed at issue, parked in p_hi/p_lo, and retired when the countdown expires.
module md_seq #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] result,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  localparam logic [4:0] MC = 5'(MULT_CYCLES);
  localparam logic [4:0] DC = 5'(DIV_CYCLES);

  logic [31:0] r_hi, r_lo, r_result, r_p_hi, r_p_lo;
  logic [4:0]  r_cnt;

  logic        w_idle, w_is_md, w_start, w_sgn, w_na, w_nb;
  logic [63:0] w_prod;
  logic [31:0] w_ua, w_ub, w_ubd, w_uq, w_ur, w_q, w_r;

  assign w_idle  = (r_cnt == 5'd0);
  assign w_is_md = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  assign w_start = w_idle && w_is_md;
  assign busy    = w_start || !w_idle;

  // Sign-extend (or zero-extend) to 64 bits; the low 64 bits of the product are exact either way.
  assign w_sgn  = (op == MD_MULT) || (op == MD_DIV);
  assign w_na   = w_sgn && a[31];
  assign w_nb   = w_sgn && b[31];
  assign w_prod = {{32{w_na}}, a} * {{32{w_nb}}, b};

  // Divide magnitudes, then fix signs: quotient truncates toward zero, remainder follows the dividend.
  // 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
  assign w_ua  = w_na ? (~a + 32'd1) : a;
  assign w_ub  = w_nb ? (~b + 32'd1) : b;
  assign w_ubd = (w_ub == 32'd0) ? 32'd1 : w_ub;
  assign w_uq  = w_ua / w_ubd;
  assign w_ur  = w_ua % w_ubd;
  assign w_q   = (w_na ^ w_nb) ? (~w_uq + 32'd1) : w_uq;
  assign w_r   = w_na ? (~w_ur + 32'd1) : w_ur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_result <= '0;
      r_p_hi   <= '0;
      r_p_lo   <= '0;
      r_cnt    <= '0;
    end else if (!w_idle) begin
      r_cnt <= r_cnt - 5'd1;
      if (r_cnt == 5'd1) begin
        r_hi <= r_p_hi;
        r_lo <= r_p_lo;
      end
    end else begin
      case (op)
        MD_MULT, MD_MULTU: begin
          r_p_hi <= w_prod[63:32];
          r_p_lo <= w_prod[31:0];
          r_cnt  <= MC;
        end
        MD_DIV, MD_DIVU: begin
          if (b == 32'd0) begin
            r_p_hi <= r_hi;
            r_p_lo <= r_lo;
          end else begin
            r_p_hi <= w_r;
            r_p_lo <= w_q;
          end
          r_cnt <= DC;
        end
        MD_MTHI: r_hi     <= a;
        MD_MTLO: r_lo     <= a;
        MD_MFHI: r_result <= r_hi;
        MD_MFLO: r_result <= r_lo;
        MD_NONE: ;
        default: ;
      endcase
    end
  end

  assign hi     = r_hi;
  assign lo     = r_lo;
  assign result = r_result;
endmodule
